// File: rtl/mem_pkg.sv
// Shared memory-path definitions: sign-mask bit positions, MMIO addresses and the
// store-buffer entry layout.
package mem_pkg;

   localparam int unsigned SM_SIGNED = 3;
   localparam int unsigned SM_WORD   = 2;
   localparam int unsigned SM_HALF   = 1;

   localparam logic [31:0] LED_ADDR = 32'h2000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sign_mask;
   } sb_entry_t;

   localparam int unsigned SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer storage: circular FIFO with per-entry valid bits and a parallel
// word-address match vector used for load hazard detection.
module sb_fifo
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  sb_entry_t        push_entry,
   input  logic             pop,
   input  logic [29:0]      match_word,
   output sb_entry_t        head_entry,
   output logic             full,
   output logic             empty,
   output logic [DEPTH-1:0] match
);

   localparam int unsigned AW = $clog2(DEPTH);

   sb_entry_t        store_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [AW:0]      count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         // Push after pop so a full-buffer push into the freed slot keeps it valid.
         if (push) begin
            store_q[tail_q] <= push_entry;
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign full       = (count_q == (AW + 1)'(DEPTH));
   assign empty      = (count_q == '0);
   assign head_entry = store_q[head_q];

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid_q[i] && (store_q[i].addr[31:2] == match_word);
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of data_mem: queues stores, drains them in idle
// slots, passes loads through and stalls loads that hit a queued store's word.
module store_buffer
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_write_data,
   input  logic        cpu_memwrite,
   input  logic        cpu_memread,
   input  logic [3:0]  cpu_sign_mask,
   output logic [31:0] cpu_read_data,
   output logic        cpu_stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_sign_mask,
   output logic        mem_memwrite,
   output logic        mem_memread,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall,
   output logic        sb_empty
);

   sb_entry_t        push_entry;
   sb_entry_t        head_entry;
   logic             full;
   logic             empty;
   logic [DEPTH-1:0] match;
   logic             hazard;
   logic             load_ok;
   logic             load_go;
   logic             issue;
   logic             push;

   assign push_entry = '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};

   sb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (issue),
      .match_word (cpu_addr[31:2]),
      .head_entry (head_entry),
      .full       (full),
      .empty      (empty),
      .match      (match)
   );

   assign hazard  = cpu_memread && (|match);
   // A full buffer lets the drain win over loads so stores cannot starve.
   assign load_ok = cpu_memread && !hazard && !full;
   assign issue   = !empty && !mem_clk_stall && !load_ok;
   assign load_go = load_ok && !mem_clk_stall;
   assign push    = cpu_memwrite && (!full || issue);

   assign cpu_stall     = (cpu_memread && !load_go) || (cpu_memwrite && !push);
   assign cpu_read_data = mem_read_data;
   assign sb_empty      = empty;

   always_comb begin
      mem_addr       = '0;
      mem_write_data = '0;
      mem_sign_mask  = '0;
      mem_memwrite   = 1'b0;
      mem_memread    = 1'b0;
      if (issue) begin
         mem_addr       = head_entry.addr;
         mem_write_data = head_entry.data;
         mem_sign_mask  = head_entry.sign_mask;
         mem_memwrite   = 1'b1;
      end else if (load_go) begin
         mem_addr      = cpu_addr;
         mem_sign_mask = cpu_sign_mask;
         mem_memread   = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer against a small data_mem model that stalls
// for one cycle after every write.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_write_data;
   logic        cpu_memwrite;
   logic        cpu_memread;
   logic [3:0]  cpu_sign_mask;
   logic [31:0] cpu_read_data;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_sign_mask;
   logic        mem_memwrite;
   logic        mem_memread;
   logic [31:0] mem_read_data;
   logic        mem_clk_stall;
   logic        sb_empty;

   int tests_run = 0;
   int fails     = 0;

   // data_mem model
   logic [31:0] dmem [0:4095] = '{default: 32'h0};
   logic        stall_q    = 1'b0;
   logic        stall_hold = 1'b0;
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   always #5 clk = ~clk;

   function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] off, input logic [3:0] m);
      logic [31:0] w;
      w = old;
      if (m[2]) w = d;
      else if (m[1]) begin
         if (off[1]) w[31:16] = d[15:0];
         else w[15:0] = d[15:0];
      end else begin
         case (off)
            2'd0: w[7:0]   = d[7:0];
            2'd1: w[15:8]  = d[7:0];
            2'd2: w[23:16] = d[7:0];
            default: w[31:24] = d[7:0];
         endcase
      end
      return w;
   endfunction

   function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [1:0] off,
                                          input logic [3:0] m);
      logic [31:0] s;
      if (m[2]) return w;
      s = w >> (off * 8);
      if (m[1]) return m[3] ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      return m[3] ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
   endfunction

   assign mem_clk_stall = stall_q | stall_hold;
   assign mem_read_data = rd_fmt(dmem[mem_addr[13:2]], mem_addr[1:0], mem_sign_mask);

   always @(posedge clk) begin
      stall_q <= mem_memwrite;
      if (mem_memwrite) begin
         dmem[mem_addr[13:2]] <= wr_merge(dmem[mem_addr[13:2]], mem_write_data,
                                          mem_addr[1:0], mem_sign_mask);
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_write_data);
      end
   end

   store_buffer #(
      .DEPTH (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_addr       (cpu_addr),
      .cpu_write_data (cpu_write_data),
      .cpu_memwrite   (cpu_memwrite),
      .cpu_memread    (cpu_memread),
      .cpu_sign_mask  (cpu_sign_mask),
      .cpu_read_data  (cpu_read_data),
      .cpu_stall      (cpu_stall),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_sign_mask  (mem_sign_mask),
      .mem_memwrite   (mem_memwrite),
      .mem_memread    (mem_memread),
      .mem_read_data  (mem_read_data),
      .mem_clk_stall  (mem_clk_stall),
      .sb_empty       (sb_empty)
   );

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds a store until accepted (bounded); returns stall cycles seen.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int stalls);
      cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m; cpu_memwrite = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (cpu_stall && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      cpu_memwrite = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [3:0] m,
                          output int stalls, output logic [31:0] data);
      cpu_addr = a; cpu_sign_mask = m; cpu_memread = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (cpu_stall && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      data = cpu_read_data;
      @(posedge clk); #1;
      cpu_memread = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      @(negedge clk);
      while (!sb_empty && n < 40) begin
         n++;
         @(negedge clk);
      end
      tests_run++;
      if (sb_empty !== 1'b1) begin
         fails++;
         $display("FAIL %s drain: sb_empty=%b required 1 within 40 cycles", name, sb_empty);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_addr = '0; cpu_write_data = '0; cpu_memwrite = 1'b0;
      cpu_memread = 1'b0; cpu_sign_mask = 4'b0100;
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({sb_empty, mem_memwrite, cpu_stall} !== 3'b100) begin
         fails++;
         $display("FAIL reset_state: empty/memwrite/stall=%b required 100",
                  {sb_empty, mem_memwrite, cpu_stall});
      end
      cpu_memread = 1'b1;
      #1;
      tests_run++;
      if ({mem_memread, cpu_stall} !== 2'b10) begin
         fails++;
         $display("FAIL reset_passthru: memread/stall=%b required 10", {mem_memread, cpu_stall});
      end
      @(posedge clk); #1;
      cpu_memread = 1'b0;
   endtask

   task automatic test_burst();
      int st;
      int base = log_addr.size();
      for (int i = 0; i < 4; i++) begin
         do_store(32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'b0100, st);
         tests_run++;
         if (st !== 0) begin
            fails++;
            $display("FAIL burst_stall[%0d]: stalls=%0d required 0", i, st);
         end
      end
      wait_empty("burst");
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (dmem[12'h40 + 12'(i)] !== 32'hA0 + 32'(i) || log_addr.size() < base + 4 ||
             log_addr[base + i] !== 32'h100 + 32'(i * 4)) begin
            fails++;
            $display("FAIL burst_mem[%0d]: word=%h required %h", i, dmem[12'h40 + 12'(i)],
                     32'hA0 + 32'(i));
         end
      end
      idle(2);
   endtask

   task automatic test_overflow();
      int st;
      int base = log_addr.size();
      stall_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_store(32'h600 + 32'(i * 4), 32'hB0 + 32'(i), 4'b0100, st);
         tests_run++;
         if (st !== 0) begin
            fails++;
            $display("FAIL ovf_fill[%0d]: stalls=%0d required 0", i, st);
         end
      end
      cpu_addr = 32'h610; cpu_write_data = 32'hB4; cpu_memwrite = 1'b1;
      repeat (2) begin
         @(negedge clk);
         tests_run++;
         if (cpu_stall !== 1'b1) begin
            fails++;
            $display("FAIL ovf_full_stall: cpu_stall=%b required 1", cpu_stall);
         end
         @(posedge clk); #1;
      end
      stall_hold = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({cpu_stall, mem_memwrite} !== 2'b01 || mem_addr !== 32'h600) begin
         fails++;
         $display("FAIL ovf_push_pop: stall/memwrite=%b addr=%h required 01 600",
                  {cpu_stall, mem_memwrite}, mem_addr);
      end
      @(posedge clk); #1;
      cpu_memwrite = 1'b0;
      do_store(32'h614, 32'hB5, 4'b0100, st);
      tests_run++;
      if (st !== 1) begin
         fails++;
         $display("FAIL ovf_sixth: stalls=%0d required 1", st);
      end
      wait_empty("overflow");
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (log_addr.size() < base + 6 || log_addr[base + i] !== 32'h600 + 32'(i * 4) ||
             log_data[base + i] !== 32'hB0 + 32'(i)) begin
            fails++;
            $display("FAIL ovf_order[%0d]: retired entry out of order or missing", i);
         end
      end
      idle(2);
   endtask

   task automatic test_raw();
      int st;
      logic [31:0] d;
      do_store(32'h200, 32'hDEADBEEF, 4'b0100, st);
      do_load(32'h200, 4'b0100, st, d);
      tests_run++;
      if (st !== 2 || d !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL raw_load: stalls=%0d data=%h required 2 deadbeef", st, d);
      end
      idle(2);
   endtask

   task automatic test_subword();
      int st;
      logic [31:0] d;
      do_store(32'h203, 32'h7F, 4'b0000, st);
      do_load(32'h201, 4'b1000, st, d);
      tests_run++;
      if (st !== 2 || d !== 32'hFFFFFFBE) begin
         fails++;
         $display("FAIL sub_lb: stalls=%0d data=%h required 2 ffffffbe", st, d);
      end
      do_load(32'h203, 4'b0000, st, d);
      tests_run++;
      if (st !== 0 || d !== 32'h0000007F) begin
         fails++;
         $display("FAIL sub_lbu: stalls=%0d data=%h required 0 0000007f", st, d);
      end
      idle(2);
   endtask

   task automatic test_nonconflict();
      int st;
      do_store(32'h400, 32'h12345678, 4'b0100, st);
      wait_empty("preload");
      idle(2);
      stall_hold = 1'b1;
      do_store(32'h300, 32'hC0, 4'b0100, st);
      do_store(32'h304, 32'hC1, 4'b0100, st);
      stall_hold = 1'b0;
      cpu_addr = 32'h400; cpu_sign_mask = 4'b0100; cpu_memread = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({cpu_stall, mem_memread, mem_memwrite} !== 3'b010 || cpu_read_data !== 32'h12345678)
      begin
         fails++;
         $display("FAIL nc_load: stall/rd/wr=%b data=%h required 010 12345678",
                  {cpu_stall, mem_memread, mem_memwrite}, cpu_read_data);
      end
      @(posedge clk); #1;
      cpu_memread = 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_memwrite !== 1'b1 || mem_addr !== 32'h300) begin
         fails++;
         $display("FAIL nc_resume: memwrite=%b addr=%h required 1 300", mem_memwrite, mem_addr);
      end
      wait_empty("nonconflict");
      idle(2);
   endtask

   task automatic test_mmio();
      int st;
      do_store(32'h2000, 32'h5, 4'b0100, st);
      wait_empty("mmio");
      tests_run++;
      if (dmem[12'h800] !== 32'h5) begin
         fails++;
         $display("FAIL mmio_led: word=%h required 00000005", dmem[12'h800]);
      end
      idle(2);
   endtask

   task automatic test_reset_mid();
      int st;
      int base;
      stall_hold = 1'b1;
      for (int i = 0; i < 3; i++) do_store(32'h500 + 32'(i * 4), 32'h11 * 32'(i + 1), 4'b0100, st);
      base = log_addr.size();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      stall_hold = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({sb_empty, mem_memwrite} !== 2'b10) begin
         fails++;
         $display("FAIL rst_mid: empty/memwrite=%b required 10", {sb_empty, mem_memwrite});
      end
      idle(6);
      tests_run++;
      if (log_addr.size() !== base || dmem[12'h140] !== 32'h0 || dmem[12'h142] !== 32'h0) begin
         fails++;
         $display("FAIL rst_discard: writes=%0d required %0d", log_addr.size(), base);
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_overflow();
      test_raw();
      test_subword();
      test_nonconflict();
      test_mmio();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
